// File: rtl/flow_counter_table_pkg.sv
// Shared dataplane definitions for the flow counter table: key width, FSM
// state encoding and the key-to-index XOR fold.
package flow_counter_table_pkg;

  localparam int FLOW_KEY_W = 96;
  localparam int MAX_IDX_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  // XOR of consecutive idx_w-bit slices of the key; the final partial slice
  // is zero-extended because the shifted remainder fills with zeros.
  function automatic logic [MAX_IDX_W-1:0] fold_key(
    input logic [FLOW_KEY_W-1:0] key,
    input int                    idx_w
  );
    logic [FLOW_KEY_W-1:0] rem;
    logic [MAX_IDX_W:0]    one_hot;
    logic [MAX_IDX_W-1:0]  mask;
    logic [MAX_IDX_W-1:0]  acc;
    rem     = key;
    one_hot = (MAX_IDX_W+1)'(1) << idx_w;
    mask    = one_hot[MAX_IDX_W-1:0] - MAX_IDX_W'(1);
    acc     = '0;
    for (int s = 0; s < FLOW_KEY_W; s++) begin
      if (s * idx_w < FLOW_KEY_W) begin
        acc = acc ^ (rem[MAX_IDX_W-1:0] & mask);
        rem = rem >> idx_w;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/flow_counter_table_flow_hash_fold.sv
// Combinational key-to-index fold used to pick the direct-mapped table entry.
module flow_hash_fold
  import flow_counter_table_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [FLOW_KEY_W-1:0] key,
  output logic [IDX_W-1:0]      idx
);

  logic [MAX_IDX_W-1:0] fold_full;
  logic                 unused_fold_hi;

  always_comb fold_full = fold_key(key, IDX_W);

  assign idx            = fold_full[IDX_W-1:0];
  assign unused_fold_hi = ^fold_full;

endmodule

// File: rtl/flow_counter_table.sv
// Direct-mapped per-flow packet counter table with a 3-state lookup/update
// pipeline, saturating statistics and a one-cycle CSR read port.
module flow_counter_table
  import flow_counter_table_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [FLOW_KEY_W-1:0]          flow_key,
  input  logic                           key_valid,
  output logic                           key_ready,
  input  logic                           clr,
  input  logic                           rd_en,
  input  logic [$clog2(NUM_ENTRIES)-1:0] rd_idx,
  output logic                           rd_done,
  output logic                           rd_entry_valid,
  output logic [FLOW_KEY_W-1:0]          rd_key,
  output logic [CNT_WIDTH-1:0]           rd_count,
  output logic [CNT_WIDTH-1:0]           insert_cnt,
  output logic [CNT_WIDTH-1:0]           collision_cnt,
  output logic [CNT_WIDTH-1:0]           drop_cnt,
  output state_t                         dbg_state
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  // Handshake: a key is accepted in any cycle where key_valid && key_ready
  // and clr is low; key_valid while key_ready is low is a counted drop.
  state_t                  state_q, state_d;
  logic                    key_ready_q, key_ready_d;
  logic [FLOW_KEY_W-1:0]   key_q, key_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    hit_q, hit_d;
  logic [IDX_W-1:0]        idx_in;

  logic [FLOW_KEY_W-1:0]   tbl_key_q [NUM_ENTRIES];
  logic [FLOW_KEY_W-1:0]   tbl_key_d [NUM_ENTRIES];
  logic [CNT_WIDTH-1:0]    tbl_cnt_q [NUM_ENTRIES];
  logic [CNT_WIDTH-1:0]    tbl_cnt_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]  tbl_vld_q, tbl_vld_d;

  logic [CNT_WIDTH-1:0]    insert_q, insert_d;
  logic [CNT_WIDTH-1:0]    coll_q, coll_d;
  logic [CNT_WIDTH-1:0]    drop_q, drop_d;

  logic                    rd_done_q, rd_done_d;
  logic                    rd_vld_q, rd_vld_d;
  logic [FLOW_KEY_W-1:0]   rd_key_q, rd_key_d;
  logic [CNT_WIDTH-1:0]    rd_cnt_q, rd_cnt_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  flow_hash_fold #(.IDX_W(IDX_W)) u_fold (
    .key (flow_key),
    .idx (idx_in)
  );

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    idx_d     = idx_q;
    hit_d     = hit_q;
    tbl_key_d = tbl_key_q;
    tbl_cnt_d = tbl_cnt_q;
    tbl_vld_d = tbl_vld_q;
    insert_d  = insert_q;
    coll_d    = coll_q;
    drop_d    = drop_q;
    rd_done_d = rd_en;
    rd_vld_d  = rd_vld_q;
    rd_key_d  = rd_key_q;
    rd_cnt_d  = rd_cnt_q;

    // Reads sample the registered table, so they see contents before any
    // write landing on the same edge.
    if (rd_en) begin
      rd_vld_d = tbl_vld_q[rd_idx];
      rd_key_d = tbl_key_q[rd_idx];
      rd_cnt_d = tbl_cnt_q[rd_idx];
    end

    if (clr) begin
      state_d   = ST_IDLE;
      hit_d     = 1'b0;
      tbl_vld_d = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) tbl_cnt_d[i] = '0;
      insert_d  = '0;
      coll_d    = '0;
      drop_d    = '0;
    end else begin
      if (key_valid && (state_q != ST_IDLE)) drop_d = sat_inc(drop_q);
      case (state_q)
        ST_IDLE: begin
          if (key_valid) begin
            key_d   = flow_key;
            idx_d   = idx_in;
            state_d = ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          hit_d   = tbl_vld_q[idx_q] && (tbl_key_q[idx_q] == key_q);
          state_d = ST_UPDATE;
        end
        ST_UPDATE: begin
          if (hit_q) begin
            tbl_cnt_d[idx_q] = sat_inc(tbl_cnt_q[idx_q]);
          end else if (!tbl_vld_q[idx_q]) begin
            tbl_key_d[idx_q] = key_q;
            tbl_vld_d[idx_q] = 1'b1;
            tbl_cnt_d[idx_q] = CNT_WIDTH'(1);
            insert_d         = sat_inc(insert_q);
          end else begin
            coll_d = sat_inc(coll_q);
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    key_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      key_ready_q <= 1'b1;
      key_q       <= '0;
      idx_q       <= '0;
      hit_q       <= 1'b0;
      tbl_key_q   <= '{default: '0};
      tbl_cnt_q   <= '{default: '0};
      tbl_vld_q   <= '0;
      insert_q    <= '0;
      coll_q      <= '0;
      drop_q      <= '0;
      rd_done_q   <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_key_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      key_ready_q <= key_ready_d;
      key_q       <= key_d;
      idx_q       <= idx_d;
      hit_q       <= hit_d;
      tbl_key_q   <= tbl_key_d;
      tbl_cnt_q   <= tbl_cnt_d;
      tbl_vld_q   <= tbl_vld_d;
      insert_q    <= insert_d;
      coll_q      <= coll_d;
      drop_q      <= drop_d;
      rd_done_q   <= rd_done_d;
      rd_vld_q    <= rd_vld_d;
      rd_key_q    <= rd_key_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  assign key_ready      = key_ready_q;
  assign rd_done        = rd_done_q;
  assign rd_entry_valid = rd_vld_q;
  assign rd_key         = rd_key_q;
  assign rd_count       = rd_cnt_q;
  assign insert_cnt     = insert_q;
  assign collision_cnt  = coll_q;
  assign drop_cnt       = drop_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_flow_counter_table.sv
// Self-checking bench for flow_counter_table: a reference table model feeds an
// expected-read queue; a 4-bit-counter instance covers count saturation.
module tb_flow_counter_table;
  import flow_counter_table_pkg::*;

  localparam int N  = 16;
  localparam int CW = 32;
  localparam int SW = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic [95:0]   flow_key  = '0;
  logic          key_valid = 1'b0;
  logic          clr       = 1'b0;
  logic          rd_en     = 1'b0;
  logic [3:0]    rd_idx    = '0;
  logic          key_ready, rd_done, rd_entry_valid;
  logic [95:0]   rd_key;
  logic [CW-1:0] rd_count, insert_cnt, collision_cnt, drop_cnt;
  state_t        dbg_state;

  flow_counter_table #(.NUM_ENTRIES(N), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flow_key(flow_key), .key_valid(key_valid),
    .key_ready(key_ready), .clr(clr), .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_done(rd_done), .rd_entry_valid(rd_entry_valid), .rd_key(rd_key),
    .rd_count(rd_count), .insert_cnt(insert_cnt), .collision_cnt(collision_cnt),
    .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  // ---------------- saturation DUT (4-bit counters) ----------------
  logic [95:0]   flow_key_s  = '0;
  logic          key_valid_s = 1'b0;
  logic          clr_s       = 1'b0;
  logic          rd_en_s     = 1'b0;
  logic [3:0]    rd_idx_s    = '0;
  logic          key_ready_s, rd_done_s, rd_entry_valid_s;
  logic [95:0]   rd_key_s;
  logic [SW-1:0] rd_count_s, insert_cnt_s, collision_cnt_s, drop_cnt_s;
  state_t        dbg_state_s;

  flow_counter_table #(.NUM_ENTRIES(N), .CNT_WIDTH(SW)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flow_key(flow_key_s), .key_valid(key_valid_s),
    .key_ready(key_ready_s), .clr(clr_s), .rd_en(rd_en_s), .rd_idx(rd_idx_s),
    .rd_done(rd_done_s), .rd_entry_valid(rd_entry_valid_s), .rd_key(rd_key_s),
    .rd_count(rd_count_s), .insert_cnt(insert_cnt_s), .collision_cnt(collision_cnt_s),
    .drop_cnt(drop_cnt_s), .dbg_state(dbg_state_s)
  );

  // ---------------- checker ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic          m_vld [N];
  logic [95:0]   m_key [N];
  logic [CW-1:0] m_cnt [N];
  logic [CW-1:0] m_ins, m_col, m_drop;

  function automatic logic [3:0] bench_idx(input logic [95:0] k);
    logic [3:0] x;
    x = '0;
    for (int n = 0; n < 24; n++) x ^= k[n*4 +: 4];
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_vld[i] = 1'b0;
      m_key[i] = '0;
      m_cnt[i] = '0;
    end
    m_ins = '0; m_col = '0; m_drop = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_vld[i] = 1'b0;
      m_cnt[i] = '0;
    end
    m_ins = '0; m_col = '0; m_drop = '0;
  endtask

  task automatic model_key(input logic [95:0] k);
    logic [3:0] ix;
    ix = bench_idx(k);
    if (m_vld[ix] && m_key[ix] == k) begin
      if (m_cnt[ix] != '1) m_cnt[ix] = m_cnt[ix] + 1;
    end else if (!m_vld[ix]) begin
      m_vld[ix] = 1'b1;
      m_key[ix] = k;
      m_cnt[ix] = 1;
      m_ins     = m_ins + 1;
    end else begin
      m_col = m_col + 1;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [128:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n && rd_done) begin
      if (exp_q.size() == 0) check("rd_extra_done", 160'(rd_done), 160'(0));
      else check("rd_entry", 160'({rd_entry_valid, rd_key, rd_count}), 160'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_key(input logic [95:0] k);
    @(posedge clk); #1;
    check("key_ready", 160'(key_ready), 160'(1));
    flow_key  = k;
    key_valid = 1'b1;
    model_key(k);
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rd(input int idx);
    @(posedge clk); #1;
    rd_en  = 1'b1;
    rd_idx = idx[3:0];
    exp_q.push_back({m_vld[idx], m_key[idx], m_cnt[idx]});
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic clr_pulse();
    @(posedge clk); #1;
    clr = 1'b1;
    model_clear();
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_ins"},  160'(insert_cnt),    160'(m_ins));
    check({tag, "_col"},  160'(collision_cnt), 160'(m_col));
    check({tag, "_drop"}, 160'(drop_cnt),      160'(m_drop));
  endtask

  task automatic send_key_s(input logic [95:0] k);
    @(posedge clk); #1;
    flow_key_s  = k;
    key_valid_s = 1'b1;
    @(posedge clk); #1;
    key_valid_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [CW-1:0] held;
    model_reset();

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_key_ready", 160'(key_ready), 160'(1));
    check("rst_state", 160'(dbg_state), 160'(ST_IDLE));
    check("rst_rd_done", 160'(rd_done), 160'(0));
    check("rst_rd_data", 160'({rd_entry_valid, rd_key, rd_count}), 160'(0));
    check_stats("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // reset while a key is in flight leaves no trace
    @(posedge clk); #1;
    flow_key = 96'h1; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("midrst_state", 160'(dbg_state), 160'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_stats("midrst");
    rd(1);

    // repeated key: one insert, count 3
    for (int i = 0; i < 3; i++) send_key(96'h1);
    check_stats("rep");
    rd(1);

    // two keys on index 0: second collides, entry untouched
    clr_pulse();
    send_key(96'h0);
    send_key(96'h11);
    check_stats("coll");
    rd(0);

    // back-to-back key_valid: second dropped
    clr_pulse();
    @(posedge clk); #1;
    flow_key = 96'h2; key_valid = 1'b1; model_key(96'h2);
    @(posedge clk); #1;
    flow_key = 96'h3; m_drop = m_drop + 1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    @(posedge clk); #1;
    check_stats("drop");
    rd(2);
    rd(3);

    // key_valid coincident with clr is ignored, not dropped
    @(posedge clk); #1;
    clr = 1'b1; key_valid = 1'b1; flow_key = 96'h4;
    model_clear();
    @(posedge clk); #1;
    clr = 1'b0; key_valid = 1'b0;
    check("clrkv_state", 160'(dbg_state), 160'(ST_IDLE));
    repeat (3) @(posedge clk);
    #1;
    check_stats("clrkv");
    rd(4);

    // read in the same cycle as an update to the same entry
    send_key(96'h1);
    @(posedge clk); #1;
    flow_key = 96'h1; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    @(posedge clk); #1;
    check("upd_state", 160'(dbg_state), 160'(ST_UPDATE));
    rd_en = 1'b1; rd_idx = 4'd1;
    exp_q.push_back({m_vld[1], m_key[1], m_cnt[1]});
    @(posedge clk); #1;
    rd_en = 1'b0;
    model_key(96'h1);
    rd(1);

    // read data holds between reads
    held = rd_count;
    repeat (2) @(posedge clk);
    #1;
    check("rd_hold_cnt", 160'(rd_count), 160'(held));
    check("rd_hold_done", 160'(rd_done), 160'(0));

    // clr during UPDATE aborts the write and wipes the table
    for (int i = 0; i < 5; i++) send_key(96'($urandom_range(0, 255)));
    @(posedge clk); #1;
    flow_key = 96'h7; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    model_clear();
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_state", 160'(dbg_state), 160'(ST_IDLE));
    check_stats("clr");
    for (int i = 0; i < N; i++) rd(i);
    send_key(96'h7);
    check_stats("postclr");
    rd(7);

    // count saturation on the 4-bit instance: 17 hits of one key
    for (int i = 0; i < 17; i++) send_key_s(96'h5);
    @(posedge clk); #1;
    rd_en_s = 1'b1; rd_idx_s = 4'd5;
    @(posedge clk); #1;
    rd_en_s = 1'b0;
    check("sat_done", 160'(rd_done_s), 160'(1));
    check("sat_vld", 160'(rd_entry_valid_s), 160'(1));
    check("sat_key", 160'(rd_key_s), 160'(96'h5));
    check("sat_cnt", 160'(rd_count_s), 160'(4'hF));
    check("sat_ins", 160'(insert_cnt_s), 160'(1));

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drain", 160'(exp_q.size()), 160'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
